// File: rtl/issue_ctrl.sv
// In-order issue controller: scoreboards pending register writes and holds
// decode on RAW/WAW hazards, on a full pipeline, or while control flow is unresolved.
module issue_ctrl #(
  parameter int REG_NUM      = 32,
  parameter int REG_W        = 5,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_valid,
  input  logic               rs1_en,
  input  logic [REG_W-1:0]   rs1,
  input  logic               rs2_en,
  input  logic [REG_W-1:0]   rs2,
  input  logic               rd_en,
  input  logic [REG_W-1:0]   rd,
  input  logic               cf_stall,
  input  logic               cf_done,
  input  logic               retire,
  input  logic               wb_en,
  input  logic [REG_W-1:0]   wb_rd,
  output logic               issue,
  output logic               stall,
  output logic [REG_NUM-1:0] pending,
  output logic [CNT_W-1:0]   inflight,
  output logic               cf_wait,
  output logic               err
);

  typedef enum logic {RUN, WAIT_CF} state_t;

  state_t             state_reg, state_next;
  logic [REG_NUM-1:0] pending_reg, pending_next;
  logic [CNT_W-1:0]   inflight_reg, inflight_next;
  logic               err_reg, err_next;

  logic hazard;
  logic full;
  logic retire_err, wb_err, cf_err;
  logic retire_ok, clr_ok;

  // Hazards look only at the registered scoreboard: no writeback bypass.
  assign hazard = (rs1_en && rs1 != '0 && pending_reg[rs1]) ||
                  (rs2_en && rs2 != '0 && pending_reg[rs2]) ||
                  (rd_en  && rd  != '0 && pending_reg[rd]);
  assign full   = (inflight_reg >= CNT_W'(MAX_INFLIGHT));

  assign retire_err = retire && (inflight_reg == '0);
  assign wb_err     = retire && wb_en && (wb_rd != '0) && !pending_reg[wb_rd];
  assign cf_err     = cf_done && (state_reg == RUN);
  assign retire_ok  = retire && !retire_err;
  assign clr_ok     = retire_ok && wb_en && (wb_rd != '0) && !wb_err;

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    stall      = 1'b0;
    cf_wait    = 1'b0;
    case (state_reg)
      RUN: begin
        issue = dec_valid && !hazard && !full;
        if (issue && cf_stall)
          state_next = WAIT_CF;
      end
      WAIT_CF: begin
        cf_wait = 1'b1;
        if (cf_done)
          state_next = RUN;
      end
      default: state_next = RUN;
    endcase
    stall = dec_valid && !issue;
  end

  // Per-register update: clear on a legal writeback, then set on issue (set wins).
  genvar gi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_sb
      if (gi == 0) begin : g_x0
        assign pending_next[gi] = 1'b0;
      end else begin : g_xn
        logic set_hit, clr_hit;
        assign set_hit = issue && rd_en && (rd == REG_W'(gi));
        assign clr_hit = clr_ok && (wb_rd == REG_W'(gi));
        assign pending_next[gi] = set_hit || (pending_reg[gi] && !clr_hit);
      end
    end
  endgenerate

  always_comb begin
    inflight_next = inflight_reg;
    if (issue && !retire_ok && !full)
      inflight_next = inflight_reg + 1'b1;
    else if (!issue && retire_ok)
      inflight_next = inflight_reg - 1'b1;
  end

  assign err_next = err_reg || retire_err || wb_err || cf_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= RUN;
      pending_reg  <= '0;
      inflight_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      inflight_reg <= inflight_next;
      err_reg      <= err_next;
    end
  end

  assign pending  = pending_reg;
  assign inflight = inflight_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: hazards, x0, control-flow wait, inflight limit, errors.
module tb_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, rs1_en, rs2_en, rd_en, cf_stall, cf_done, retire, wb_en;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic        issue, stall, cf_wait, err;
  logic [31:0] pending;
  logic [2:0]  inflight;

  int n_checks = 0;
  int n_fail   = 0;

  issue_ctrl dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid),
    .rs1_en(rs1_en), .rs1(rs1), .rs2_en(rs2_en), .rs2(rs2),
    .rd_en(rd_en), .rd(rd), .cf_stall(cf_stall), .cf_done(cf_done),
    .retire(retire), .wb_en(wb_en), .wb_rd(wb_rd),
    .issue(issue), .stall(stall), .pending(pending), .inflight(inflight),
    .cf_wait(cf_wait), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 0; rs1_en = 0; rs2_en = 0; rd_en = 0;
    rs1 = 0; rs2 = 0; rd = 0; cf_stall = 0; cf_done = 0;
    retire = 0; wb_en = 0; wb_rd = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    #3;
    rst = 0;
    cyc();
  endtask

  initial begin
    idle();
    rst = 1;
    #2;
    check("rst_pending", pending, 0);
    check("rst_inflight", 32'(inflight), 0);
    check("rst_issue", 32'(issue), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_cf_wait", 32'(cf_wait), 0);
    check("rst_err", 32'(err), 0);
    cyc();
    rst = 0;
    cyc();

    // Reset mid-run
    dec_valid = 1; rd_en = 1; rd = 2; #1;
    check("mr_issue0", 32'(issue), 1);
    cyc();
    rd_en = 0; rd = 0; #1;
    check("mr_issue1", 32'(issue), 1);
    cyc();
    idle(); #1;
    check("mr_pending", pending, 32'h0000_0004);
    check("mr_inflight", 32'(inflight), 2);
    rst = 1; #1;
    check("mr_pending_rst", pending, 0);
    check("mr_inflight_rst", 32'(inflight), 0);
    check("mr_issue_rst", 32'(issue), 0);
    check("mr_err_rst", 32'(err), 0);
    #1 rst = 0;
    cyc();

    // RAW on x5
    dec_valid = 1; rd_en = 1; rd = 5; #1;
    check("raw_issue_add", 32'(issue), 1);
    cyc();
    rd_en = 0; rd = 0; rs1_en = 1; rs1 = 5; #1;
    check("raw_pending_set", pending, 32'h0000_0020);
    check("raw_stall0", 32'(stall), 1);
    check("raw_issue0", 32'(issue), 0);
    cyc();
    retire = 1; wb_en = 1; wb_rd = 5; #1;
    check("raw_nobypass_stall", 32'(stall), 1);
    check("raw_nobypass_issue", 32'(issue), 0);
    cyc();
    retire = 0; wb_en = 0; wb_rd = 0; #1;
    check("raw_pending_clr", pending, 0);
    check("raw_issue_after_wb", 32'(issue), 1);
    check("raw_stall_after_wb", 32'(stall), 0);
    cyc();
    idle(); retire = 1; #1;
    check("raw_inflight", 32'(inflight), 1);
    cyc();
    idle(); #1;
    check("raw_drained", 32'(inflight), 0);

    // x0 immunity
    dec_valid = 1; rd_en = 1; rd = 0; rs1_en = 1; rs1 = 0; #1;
    check("x0_issue0", 32'(issue), 1);
    cyc();
    check("x0_pending0", pending, 0);
    check("x0_issue1", 32'(issue), 1);
    cyc();
    idle(); retire = 1; #1;
    check("x0_pending1", pending, 0);
    check("x0_inflight", 32'(inflight), 2);
    cyc(); cyc();
    idle(); #1;
    check("x0_drained", 32'(inflight), 0);

    // Control flow wait
    dec_valid = 1; cf_stall = 1; #1;
    check("cf_issue_jal", 32'(issue), 1);
    cyc();
    cf_stall = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) cf_done = 1;
      #1;
      check($sformatf("cf_wait_c%0d", c), 32'(cf_wait), 1);
      check($sformatf("cf_stall_c%0d", c), 32'(stall), 1);
      check($sformatf("cf_issue_c%0d", c), 32'(issue), 0);
      cyc();
    end
    cf_done = 0; #1;
    check("cf_wait_c4", 32'(cf_wait), 0);
    check("cf_issue_c4", 32'(issue), 1);
    cyc();
    idle(); retire = 1; #1;
    check("cf_err", 32'(err), 0);
    cyc(); cyc();
    idle(); #1;
    check("cf_drained", 32'(inflight), 0);

    // Inflight limit
    dec_valid = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("lim_issue%0d", k), 32'(issue), 1);
      cyc();
    end
    retire = 1; #1;
    check("lim_issue_retire_same", 32'(issue), 1);
    cyc();
    retire = 0; #1;
    check("lim_inflight_same", 32'(inflight), 3);
    check("lim_issue3", 32'(issue), 1);
    cyc();
    #1;
    check("lim_inflight_full", 32'(inflight), 4);
    check("lim_stall_full", 32'(stall), 1);
    check("lim_issue_full", 32'(issue), 0);
    retire = 1; #1;
    check("lim_issue_full_ret", 32'(issue), 0);
    cyc();
    retire = 0; #1;
    check("lim_inflight_3", 32'(inflight), 3);
    check("lim_issue5", 32'(issue), 1);
    cyc();
    idle(); retire = 1; #1;
    check("lim_inflight_4b", 32'(inflight), 4);
    for (int k = 0; k < 4; k++) cyc();
    idle(); #1;
    check("lim_drained", 32'(inflight), 0);
    check("lim_err", 32'(err), 0);

    // Protocol errors
    retire = 1; #1;
    cyc();
    retire = 0; #1;
    check("perr_retire_err", 32'(err), 1);
    check("perr_retire_inflight", 32'(inflight), 0);
    cf_done = 1; #1;
    cyc();
    cf_done = 0; dec_valid = 1; #1;
    check("perr_cf_err", 32'(err), 1);
    check("perr_cf_state", 32'(cf_wait), 0);
    check("perr_cf_issue", 32'(issue), 1);
    cyc();
    idle();
    do_reset();
    #1;
    check("perr_err_cleared", 32'(err), 0);

    // Writeback to a register that is not pending
    dec_valid = 1; rd_en = 1; rd = 3; #1;
    cyc();
    idle(); retire = 1; wb_en = 1; wb_rd = 7; #1;
    cyc();
    idle(); #1;
    check("wberr_err", 32'(err), 1);
    check("wberr_pending_kept", pending, 32'h0000_0008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
